// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Shared types for the iterative integer divider.
//   div_op_t    : funct3[1:0] encoding of DIV / DIVU / REM / REMU
//   div_state_t : divider control states
// ---------------------------------------------------------------------------
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP  = 2'b00,
        DIVU_OP = 2'b01,
        REM_OP  = 2'b10,
        REMU_OP = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bit 0 of the encoding marks the unsigned flavours.
    function automatic logic op_is_signed(div_op_t op);
        return (op == DIV_OP) || (op == REM_OP);
    endfunction

    // Bit 1 of the encoding selects the remainder as the result.
    function automatic logic op_is_rem(div_op_t op);
        return (op == REM_OP) || (op == REMU_OP);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step.
//   rem_in       : partial remainder, always < divisor
//   divisor      : unsigned divisor magnitude
//   dividend_bit : next dividend bit shifted into the remainder
//   rem_out      : partial remainder after the step
//   q_bit        : quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem_in, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};

    // XLEN+1 bits suffice: since rem_in < divisor, a set shifted MSB always
    // means the trial is non-negative, otherwise trial MSB is a true sign.
    assign q_bit   = shifted[XLEN] | ~trial[XLEN];
    assign rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative integer divider (DIV/DIVU/REM/REMU) retiring BITS_PER_CYCLE
// quotient bits per clock, with divide-by-zero and signed-overflow shortcuts.
//   clk, reset      : clock, asynchronous active-high reset
//   flush_i         : kill any in-flight or pending operation
//   req_v_i/ready_o : request handshake (op_i, tag_i, rs1_data_i, rs2_data_i)
//   busy_o          : unit is not idle
//   resp_v_o/ready_i: response handshake (resp_tag_o, resp_data_o)
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             req_v_i,
    output logic             req_ready_o,
    input  logic [1:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    output logic             busy_o,
    output logic             resp_v_o,
    input  logic             resp_ready_i,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [XLEN-1:0]  resp_data_o
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    div_state_t       state, state_next;
    div_op_t          op;
    logic             rem_sel_q, q_neg_q, r_neg_q;
    logic [XLEN-1:0]  dividend_q, divisor_q, rem_q, data_q;
    logic [CNT_W-1:0] count_q;
    logic [TAG_W-1:0] tag_q;

    // Request decode
    logic            accept, signed_req, rs1_neg, rs2_neg;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_data;

    assign op          = div_op_t'(op_i);
    assign req_ready_o = (state == IDLE) && !flush_i;
    assign accept      = req_v_i && req_ready_o;
    assign signed_req  = op_is_signed(op);
    assign rs1_neg     = signed_req && rs1_data_i[XLEN-1];
    assign rs2_neg     = signed_req && rs2_data_i[XLEN-1];
    assign div_zero    = (rs2_data_i == '0);
    assign overflow    = signed_req && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (rs2_data_i == '1);
    assign special     = div_zero || overflow;

    always_comb begin
        if (op_is_rem(op)) special_data = div_zero ? rs1_data_i : '0;
        else               special_data = div_zero ? '1 : rs1_data_i;
    end

    // Chain of restoring steps; the dividend register doubles as the
    // quotient register, quotient bits entering as dividend bits leave.
    logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_chain;
    logic [BITS_PER_CYCLE-1:0]         q_bits;
    logic [XLEN-1:0]                   quot_next, rem_next, q_final, r_final;

    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in       (rem_chain[k]),
            .divisor      (divisor_q),
            .dividend_bit (dividend_q[XLEN-1-k]),
            .rem_out      (rem_chain[k+1]),
            .q_bit        (q_bits[BITS_PER_CYCLE-1-k])
        );
    end

    assign quot_next = {dividend_q[XLEN-BITS_PER_CYCLE-1:0], q_bits};
    assign rem_next  = rem_chain[BITS_PER_CYCLE];
    assign q_final   = q_neg_q ? -quot_next : quot_next;
    assign r_final   = r_neg_q ? -rem_next  : rem_next;

    // Control FSM
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = special ? DONE : BUSY;
            BUSY:    if (count_q == CNT_W'(1)) state_next = DONE;
            DONE:    if (resp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Flush wins over arriving requests and response handshakes.
        if (flush_i) state_next = IDLE;
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_sel_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            count_q    <= '0;
            tag_q      <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else if (accept) begin
            rem_sel_q  <= op_is_rem(op);
            q_neg_q    <= rs1_neg ^ rs2_neg;
            r_neg_q    <= rs1_neg;
            tag_q      <= tag_i;
            dividend_q <= rs1_neg ? -rs1_data_i : rs1_data_i;
            divisor_q  <= rs2_neg ? -rs2_data_i : rs2_data_i;
            rem_q      <= '0;
            count_q    <= special ? '0 : CNT_W'(STEPS);
            if (special) data_q <= special_data;
        end else if (state == BUSY) begin
            dividend_q <= quot_next;
            rem_q      <= rem_next;
            count_q    <= count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) data_q <= rem_sel_q ? r_final : q_final;
        end
    end

    assign busy_o      = (state != IDLE);
    assign resp_v_o    = (state == DONE);
    assign resp_tag_o  = tag_q;
    assign resp_data_o = data_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised iterative integer divider for the RV32/RV64 pipeline; successor to the fixed 32-bit, radix-2 divide path inside the execution stage.
- Executes DIV/DIVU/REM/REMU with a valid/ready request and response handshake, a destination tag and pipeline flush.
- Retires a configurable number of quotient bits per cycle and short-cuts divide-by-zero and signed overflow.
- Sits beside the execution stage; the stage issues requests, and the writeback mux consumes responses.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- BITS_PER_CYCLE, 1, quotient bits retired per cycle (1, 2 or 4; must divide XLEN).
- TAG_W, 5, width of the destination tag (rd index).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- flush_i  input  1  kill any in-flight or pending operation
- req_v_i  input  1  request valid
- req_ready_o  output  1  unit can accept a request
- op_i  input  2  funct3[1:0]: bit0 = unsigned, bit1 = remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- tag_i  input  TAG_W  destination register tag
- rs1_data_i  input  XLEN  dividend
- rs2_data_i  input  XLEN  divisor
- busy_o  output  1  state is not IDLE
- resp_v_o  output  1  result valid
- resp_ready_i  input  1  consumer accepts result
- resp_tag_o  output  TAG_W  tag of the result
- resp_data_o  output  XLEN  quotient or remainder

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high, applied immediately with no wait for an edge.
- Reset values: state=IDLE, req_ready_o=1, busy_o=0, resp_v_o=0, resp_data_o=0, resp_tag_o=0, iteration counter=0.
- States:
  - IDLE, BUSY, DONE.
  - req_ready_o = (state==IDLE) & !flush_i.
  - Accept = req_v_i & req_ready_o at a rising edge.
- IDLE → BUSY on accept, in the normal case:
  - Latch op and tag.
  - Latch |rs1| and |rs2| as unsigned magnitudes; take the absolute value only for signed ops with the MSB set.
  - Latch q_neg = signed & (rs1 MSB ^ rs2 MSB) and r_neg = signed & rs1 MSB.
  - Clear the partial remainder; counter = XLEN/BITS_PER_CYCLE.
- IDLE → DONE on accept, special cases (1-cycle latency):
  - Divisor==0: quotient = all ones; remainder = rs1 unmodified.
  - Signed overflow (rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): quotient = rs1; remainder = 0.
- BUSY, each edge:
  - Perform BITS_PER_CYCLE chained restoring steps.
  - Each step: shift the partial remainder left by one, shifting in the dividend MSB; trial-subtract the divisor at XLEN+1 bits.
  - Non-negative trial: keep the difference and set quotient bit = 1. Negative trial: restore and set quotient bit = 0.
  - Decrement the counter.
- BUSY → DONE at the edge where counter==1:
  - Apply sign fix in the same edge: negate the quotient if q_neg, negate the remainder if r_neg.
  - Register resp_data_o as the quotient if op[1]=0, else the remainder. Set resp_v_o=1.
- Normal latency: resp_v_o rises XLEN/BITS_PER_CYCLE edges after the accept edge (32 for defaults).
- DONE:
  - resp_v_o, resp_data_o and resp_tag_o stay stable until resp_v_o & resp_ready_i at an edge, then → IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- flush_i:
  - At any edge, flush_i forces IDLE and resp_v_o=0; it overrides an arriving request and a simultaneous response handshake.
  - While flush_i is high, req_ready_o=0.
- reset mid-operation: state is discarded; no response is emitted.
- busy_o = (state != IDLE).
- All arithmetic is unsigned after magnitude extraction. No X is propagated on outputs when idle.

Decomposition:
- instruction_pkg gains:
  - the div_op_t typedef (DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11);
  - the div_state_t enum (IDLE, BUSY, DONE).
- One combinational sub-module, div_step: a single radix-2 restoring step, parametrised by XLEN.
  - Inputs: partial remainder, divisor, dividend bit.
  - Outputs: next remainder, quotient bit.
  - Instantiated BITS_PER_CYCLE times in a generate chain.

Test Plan:
- Signed ops, defaults:
  - DIV 20 / -3 (0xFFFFFFFD) → resp_data_o=0xFFFFFFFA exactly 32 cycles after accept.
  - REM 20 / -3 → 0x00000002.
  - REM -20 / 3 → 0xFFFFFFFE.
- Unsigned ops: DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU same operands → 0x00000001; resp_tag_o equals the issued tag.
- Divide-by-zero: DIV 7 / 0 → 0xFFFFFFFF and REMU 7 / 0 → 0x00000007, each with resp_v_o one cycle after accept.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM same operands → 0; both at 1-cycle latency.
- Backpressure: hold resp_ready_i=0 for 5 cycles in DONE → outputs stable and req_ready_o=0; after the handshake, req_ready_o=1 the next cycle.
- Kill paths:
  - flush_i on iteration 10 → resp_v_o never rises and IDLE the next cycle; a following DIVU 100/7 returns 14.
  - reset asserted mid-BUSY → all outputs return to reset values immediately.
- Repeat the signed and unsigned cases with BITS_PER_CYCLE=4 (latency 8) and XLEN=64 (DIV -1/1 → all ones).
